// File: rtl/bsg_axil_mcl_pkg.sv
// Shared register offsets and AXI-Lite response codes for the manycore-link
// host register window.
package bsg_axil_mcl_pkg;

    localparam int word_w_gp        = 32;
    localparam int words_per_pkt_gp = 4;

    localparam logic [15:0] tx_vac_off_gp   = 16'h0000;
    localparam logic [15:0] tx_data_off_gp  = 16'h0004;
    localparam logic [15:0] rsp_occ_off_gp  = 16'h0008;
    localparam logic [15:0] rsp_data_off_gp = 16'h000C;
    localparam logic [15:0] req_occ_off_gp  = 16'h0018;
    localparam logic [15:0] req_data_off_gp = 16'h001C;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_e;

endpackage

// File: rtl/bsg_axil_mcl_rx_unpacker.sv
// Inbound packet FIFO that hands out one 32-bit word per pop; the head packet
// is retired once its fourth word has been popped.
module bsg_axil_mcl_rx_unpacker
    import bsg_axil_mcl_pkg::*;
#(
    parameter int pkt_width_p = 128,
    parameter int fifo_els_p  = 4,
    parameter int occ_width_p = $clog2(words_per_pkt_gp * fifo_els_p + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [pkt_width_p-1:0] data_i,
    output logic                   ready_o,
    input  logic                   pop_i,
    output logic [word_w_gp-1:0]   word_o,
    output logic                   empty_o,
    output logic [occ_width_p-1:0] occ_o
);

    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    logic [pkt_width_p-1:0] mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic [1:0]             idx_q, idx_d;
    logic [occ_width_p-1:0] occ_q, occ_d;
    logic                   full_q, full_d;
    logic                   push, pop_word, pop_pkt;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready comes from the registered full flag, so a same-cycle pop never
    // opens a slot early and a push at full is simply refused.
    assign ready_o  = ~full_q & reset_n_i;
    assign empty_o  = (cnt_q == '0);
    assign push     = v_i & ready_o;
    assign pop_word = pop_i & ~empty_o;
    assign pop_pkt  = pop_word & (idx_q == 2'd3);
    assign word_o   = mem_q[rd_ptr_q][{idx_q, 5'd0} +: word_w_gp];
    assign occ_o    = occ_q;

    always_comb begin
        wr_ptr_d = push    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_pkt ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        idx_d    = pop_word ? idx_q + 2'd1 : idx_q;
        cnt_d    = cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop_pkt);
        full_d   = (cnt_d == cnt_w_lp'(fifo_els_p));
        occ_d    = occ_q + (push ? occ_width_p'(words_per_pkt_gp) : '0)
                         - occ_width_p'(pop_word);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_axil_mcl_responder.sv
// AXI-Lite slave for the host side of the manycore link: assembles TX packets
// from word writes and serves RSP/REQ packets one word per read.
module bsg_axil_mcl_responder
    import bsg_axil_mcl_pkg::*;
#(
    parameter int          axil_addr_width_p = 32,
    parameter int          axil_data_width_p = 32,
    parameter int          pkt_width_p       = 128,
    parameter int          fifo_els_p        = 4,
    parameter logic [15:0] base_addr_p       = 16'h1000
) (
    input  logic                         pcie_clk_i,
    input  logic                         pcie_reset_n_i,

    input  logic                         s_axil_awvalid_i,
    output logic                         s_axil_awready_o,
    input  logic [axil_addr_width_p-1:0] s_axil_awaddr_i,
    input  logic                         s_axil_wvalid_i,
    output logic                         s_axil_wready_o,
    input  logic [axil_data_width_p-1:0] s_axil_wdata_i,
    input  logic [3:0]                   s_axil_wstrb_i,
    output logic                         s_axil_bvalid_o,
    input  logic                         s_axil_bready_i,
    output logic [1:0]                   s_axil_bresp_o,

    input  logic                         s_axil_arvalid_i,
    output logic                         s_axil_arready_o,
    input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
    output logic                         s_axil_rvalid_o,
    input  logic                         s_axil_rready_i,
    output logic [axil_data_width_p-1:0] s_axil_rdata_o,
    output logic [1:0]                   s_axil_rresp_o,

    output logic [pkt_width_p-1:0]       tx_data_o,
    output logic                         tx_v_o,
    input  logic                         tx_ready_i,

    input  logic [pkt_width_p-1:0]       rsp_data_i,
    input  logic                         rsp_v_i,
    output logic                         rsp_ready_o,

    input  logic [pkt_width_p-1:0]       req_data_i,
    input  logic                         req_v_i,
    output logic                         req_ready_o
);

    localparam int occ_width_lp = $clog2(words_per_pkt_gp * fifo_els_p + 1);
    localparam int buf_width_lp = pkt_width_p - axil_data_width_p;

    logic [15:0] wr_off, rd_off;
    logic        wr_is_tx, tx_block, wr_hs, ar_rdy, ar_hs;
    logic [2:0]  tx_vac;

    logic                         bvalid_q, bvalid_d;
    axil_resp_e                   bresp_q, bresp_d;
    logic                         rvalid_q, rvalid_d;
    logic [axil_data_width_p-1:0] rdata_q, rdata_d;
    axil_resp_e                   rresp_q, rresp_d;
    logic [1:0]                   tx_cnt_q, tx_cnt_d;
    logic [buf_width_lp-1:0]      tx_buf_q, tx_buf_d;
    logic [pkt_width_p-1:0]       tx_data_q, tx_data_d;
    logic                         tx_v_q, tx_v_d;

    logic                         rsp_pop, rsp_empty, req_pop, req_empty;
    logic [word_w_gp-1:0]         rsp_word, req_word;
    logic [occ_width_lp-1:0]      rsp_occ, req_occ;

    logic unused_ok;
    assign unused_ok = ^{s_axil_wstrb_i, s_axil_awaddr_i, s_axil_araddr_i};

    assign wr_off   = s_axil_awaddr_i[15:0] - base_addr_p;
    assign rd_off   = s_axil_araddr_i[15:0] - base_addr_p;
    assign wr_is_tx = (wr_off == tx_data_off_gp);
    // Only a packet-completing write needs the output register to be free.
    assign tx_block = wr_is_tx & (tx_cnt_q == 2'd3) & tx_v_q & ~tx_ready_i;
    assign wr_hs    = s_axil_awvalid_i & s_axil_wvalid_i & ~bvalid_q & ~tx_block
                      & pcie_reset_n_i;
    assign ar_rdy   = ~rvalid_q & pcie_reset_n_i;
    assign ar_hs    = s_axil_arvalid_i & ar_rdy;
    // A packet waiting in the output register reports no free words.
    assign tx_vac   = tx_v_q ? 3'd0 : 3'd4 - {1'b0, tx_cnt_q};

    assign s_axil_awready_o = wr_hs;
    assign s_axil_wready_o  = wr_hs;
    assign s_axil_bvalid_o  = bvalid_q;
    assign s_axil_bresp_o   = bresp_q;
    assign s_axil_arready_o = ar_rdy;
    assign s_axil_rvalid_o  = rvalid_q;
    assign s_axil_rdata_o   = rdata_q;
    assign s_axil_rresp_o   = rresp_q;
    assign tx_data_o        = tx_data_q;
    assign tx_v_o           = tx_v_q;

    always_comb begin
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        tx_cnt_d  = tx_cnt_q;
        tx_buf_d  = tx_buf_q;
        tx_data_d = tx_data_q;
        tx_v_d    = tx_v_q;
        if (tx_v_q & tx_ready_i) tx_v_d = 1'b0;
        if (bvalid_q & s_axil_bready_i) bvalid_d = 1'b0;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_is_tx ? OKAY : SLVERR;
            if (wr_is_tx) begin
                if (tx_cnt_q == 2'd3) begin
                    tx_data_d = {s_axil_wdata_i, tx_buf_q};
                    tx_v_d    = 1'b1;
                    tx_cnt_d  = 2'd0;
                end else begin
                    tx_buf_d[{tx_cnt_q, 5'd0} +: axil_data_width_p] = s_axil_wdata_i;
                    tx_cnt_d = tx_cnt_q + 2'd1;
                end
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rsp_pop  = 1'b0;
        req_pop  = 1'b0;
        if (rvalid_q & s_axil_rready_i) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = SLVERR;
            case (rd_off)
                tx_vac_off_gp: begin
                    rdata_d = axil_data_width_p'(tx_vac);
                    rresp_d = OKAY;
                end
                rsp_occ_off_gp: begin
                    rdata_d = axil_data_width_p'(rsp_occ);
                    rresp_d = OKAY;
                end
                req_occ_off_gp: begin
                    rdata_d = axil_data_width_p'(req_occ);
                    rresp_d = OKAY;
                end
                rsp_data_off_gp: if (!rsp_empty) begin
                    rdata_d = rsp_word;
                    rresp_d = OKAY;
                    rsp_pop = 1'b1;
                end
                req_data_off_gp: if (!req_empty) begin
                    rdata_d = req_word;
                    rresp_d = OKAY;
                    req_pop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pcie_clk_i or negedge pcie_reset_n_i) begin
        if (!pcie_reset_n_i) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            tx_cnt_q  <= '0;
            tx_buf_q  <= '0;
            tx_data_q <= '0;
            tx_v_q    <= 1'b0;
        end else begin
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_buf_q  <= tx_buf_d;
            tx_data_q <= tx_data_d;
            tx_v_q    <= tx_v_d;
        end
    end

    bsg_axil_mcl_rx_unpacker #(
        .pkt_width_p (pkt_width_p),
        .fifo_els_p  (fifo_els_p),
        .occ_width_p (occ_width_lp)
    ) rsp_unpacker (
        .clk_i     (pcie_clk_i),
        .reset_n_i (pcie_reset_n_i),
        .v_i       (rsp_v_i),
        .data_i    (rsp_data_i),
        .ready_o   (rsp_ready_o),
        .pop_i     (rsp_pop),
        .word_o    (rsp_word),
        .empty_o   (rsp_empty),
        .occ_o     (rsp_occ)
    );

    bsg_axil_mcl_rx_unpacker #(
        .pkt_width_p (pkt_width_p),
        .fifo_els_p  (fifo_els_p),
        .occ_width_p (occ_width_lp)
    ) req_unpacker (
        .clk_i     (pcie_clk_i),
        .reset_n_i (pcie_reset_n_i),
        .v_i       (req_v_i),
        .data_i    (req_data_i),
        .ready_o   (req_ready_o),
        .pop_i     (req_pop),
        .word_o    (req_word),
        .empty_o   (req_empty),
        .occ_o     (req_occ)
    );

endmodule
